rs232_rx_fifo: RTL and testbench

- Downstream stage of the rs232 receiver; drains its single-character holding register into a small FIFO.
- Drains on `rcvReady`. Acknowledges each character to the receiver with a one-cycle `readSR` pulse.
- Presents buffered characters to the core with a first-word-fall-through valid/take handshake.
- Counts buffered characters and flags lost characters with a sticky overflow bit.

---
 rtl/rs232_rx_fifo.sv | 84 ++++++++
 tb/tb_rs232_rx_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rs232_rx_fifo.sv
// rs232_rx_fifo: drains the receiver's holding register into a small
// first-word-fall-through FIFO, acknowledges each captured character with a
// one-cycle readSR pulse, and flags characters lost to a full FIFO.
module rs232_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          Ph0,
    input  logic          Reset_n,
    input  logic [7:0]    rcvData,
    input  logic          rcvReady,
    output logic          readSR,
    output logic [7:0]    rxData,
    output logic          rxValid,
    input  logic          rxTake,
    output logic [AW:0]   rxCount,
    output logic          overflow,
    input  logic          clrOvf
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;

    logic cap;
    logic pop;
    logic full;
    logic push;
    logic drop;

    // Capture/push/pop decisions; ~readSR blocks re-capturing the character
    // the receiver has not yet had time to release. A pop in the same cycle
    // frees a slot, so a full FIFO still accepts the new character.
    always_comb begin
        cap  = rcvReady & ~readSR;
        pop  = rxTake & rxValid;
        full = (rxCount == FULL_COUNT);
        push = cap & (~full | pop);
        drop = cap & full & ~pop;
    end

    assign rxValid = (rxCount != '0);
    assign rxData  = mem[rdPtr];

    // Control state: acknowledge pulse, pointers, occupancy and sticky overflow.
    always_ff @(posedge Ph0 or negedge Reset_n) begin
        if (!Reset_n) begin
            readSR   <= 1'b0;
            wrPtr    <= '0;
            rdPtr    <= '0;
            rxCount  <= '0;
            overflow <= 1'b0;
        end else begin
            readSR <= cap;
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   rxCount <= rxCount + 1'b1;
                2'b01:   rxCount <= rxCount - 1'b1;
                default: rxCount <= rxCount;
            endcase
            // A drop in the same cycle as clrOvf wins so no loss goes unreported.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clrOvf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Character storage; not reset, contents are only meaningful while counted.
    always_ff @(posedge Ph0) begin
        if (push) begin
            mem[wrPtr] <= rcvData;
        end
    end

endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Testbench for rs232_rx_fifo: directed character sequences; expected
// characters are queued when sent and compared whenever the core takes one.
module tb_rs232_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          Ph0;
    logic          Reset_n;
    logic [7:0]    rcvData;
    logic          rcvReady;
    logic          readSR;
    logic [7:0]    rxData;
    logic          rxValid;
    logic          rxTake;
    logic [AW:0]   rxCount;
    logic          overflow;
    logic          clrOvf;

    int checks = 0;
    int errors = 0;
    int expCount = 0;
    bit trackCount = 0;
    logic [7:0] expQ [$];

    rs232_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Ph0      (Ph0),
        .Reset_n  (Reset_n),
        .rcvData  (rcvData),
        .rcvReady (rcvReady),
        .readSR   (readSR),
        .rxData   (rxData),
        .rxValid  (rxValid),
        .rxTake   (rxTake),
        .rxCount  (rxCount),
        .overflow (overflow),
        .clrOvf   (clrOvf)
    );

    initial Ph0 = 1'b0;
    always #5 Ph0 = ~Ph0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted take must present the oldest queued character.
    always @(negedge Ph0) begin
        if (Reset_n && rxValid && rxTake) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL rxData: got %0h expected nothing (queue empty)", rxData);
            end else begin
                logic [7:0] e;
                e = expQ.pop_front();
                if (rxData !== e) begin
                    errors++;
                    $display("FAIL rxData: got %0h expected %0h at %0t", rxData, e, $time);
                end
            end
        end
    end

    // One clock; outputs are looked at 1 time unit after the edge.
    task automatic tick();
        @(posedge Ph0);
        #1;
        if (trackCount) chk("rxCount", int'(rxCount), expCount);
    endtask

    // Offer one character for one capture; readSR must pulse for exactly one cycle.
    task automatic sendChar(input logic [7:0] v, input bit take, input bit clr, input bit store);
        rcvData  = v;
        rcvReady = 1'b1;
        rxTake   = take;
        clrOvf   = clr;
        if (store) expQ.push_back(v);
        if (store && !take) expCount++;
        if (!store && take && expCount > 0) expCount--;
        tick();
        chk("readSR_hi", int'(readSR), 1);
        rcvReady = 1'b0;
        rxTake   = 1'b0;
        clrOvf   = 1'b0;
        tick();
        chk("readSR_lo", int'(readSR), 0);
    endtask

    task automatic takeOne();
        rxTake = 1'b1;
        if (expCount > 0) expCount--;
        tick();
        rxTake = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        Reset_n  = 1'b1;
        rcvData  = 8'h00;
        rcvReady = 1'b0;
        rxTake   = 1'b0;
        clrOvf   = 1'b0;
        #2 Reset_n = 1'b0;
        #1;
        chk("rst_readSR", int'(readSR), 0);
        chk("rst_rxValid", int'(rxValid), 0);
        chk("rst_rxCount", int'(rxCount), 0);
        chk("rst_overflow", int'(overflow), 0);
        @(posedge Ph0);
        @(posedge Ph0);
        #1 Reset_n = 1'b1;
        trackCount = 1;

        // Single character
        sendChar(8'h41, 0, 0, 1);
        chk("single_valid", int'(rxValid), 1);
        chk("single_data", int'(rxData), 'h41);
        takeOne();
        chk("single_drained", int'(rxValid), 0);

        // Receiver keeps ready high through the readSR cycle: one capture only
        rcvData  = 8'h55;
        rcvReady = 1'b1;
        expQ.push_back(8'h55);
        expCount++;
        tick();
        chk("dbl_readSR1", int'(readSR), 1);
        tick();
        chk("dbl_readSR2", int'(readSR), 0);
        rcvReady = 1'b0;
        tick();
        tick();
        chk("dbl_count", int'(rxCount), 1);
        takeOne();

        // Fill to full, then one lost character
        for (int i = 0; i < 16; i++) sendChar(8'(i), 0, 0, 1);
        chk("full_count", int'(rxCount), 16);
        chk("full_ovf", int'(overflow), 0);
        sendChar(8'h10, 0, 0, 0);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_count", int'(rxCount), 16);
        clrOvf = 1'b1;
        tick();
        clrOvf = 1'b0;
        chk("ovf_clr", int'(overflow), 0);

        // Full with simultaneous take: 0x00 leaves, 0xAA enters at the tail
        sendChar(8'hAA, 1, 0, 1);
        chk("fulltake_ovf", int'(overflow), 0);
        chk("fulltake_count", int'(rxCount), 16);
        for (int i = 0; i < 16; i++) takeOne();
        chk("drain_empty", int'(rxValid), 0);

        // Wrap-around with bounded random occupancy
        for (int i = 0; i < 40; i++) begin
            sendChar(8'(i), 0, 0, 1);
            while (expCount >= 10 || (expCount > 0 && $urandom_range(0, 2) == 0)) takeOne();
        end
        while (expCount > 0) takeOne();
        chk("wrap_empty", int'(expQ.size()), 0);

        // Reset mid-operation with 5 buffered and overflow set
        for (int i = 0; i < 16; i++) sendChar(8'(8'h20 + i), 0, 0, 1);
        sendChar(8'h30, 0, 0, 0);
        for (int i = 0; i < 11; i++) takeOne();
        chk("pre_rst_count", int'(rxCount), 5);
        chk("pre_rst_ovf", int'(overflow), 1);
        rcvData  = 8'h77;
        rcvReady = 1'b1;
        expCount++;
        tick();
        chk("pre_rst_readSR", int'(readSR), 1);
        #2 Reset_n = 1'b0;
        #1;
        chk("async_readSR", int'(readSR), 0);
        chk("async_count", int'(rxCount), 0);
        chk("async_valid", int'(rxValid), 0);
        chk("async_ovf", int'(overflow), 0);
        expQ.delete();
        expCount = 0;
        tick();
        #1 Reset_n = 1'b1;
        expQ.push_back(8'h77);
        expCount = 1;
        tick();
        chk("post_rst_readSR", int'(readSR), 1);
        rcvReady = 1'b0;
        tick();

        // Overflow set wins over a coinciding clear
        for (int i = 0; i < 15; i++) sendChar(8'(8'h80 + i), 0, 0, 1);
        sendChar(8'h90, 0, 0, 0);
        chk("ovf2_set", int'(overflow), 1);
        sendChar(8'h91, 0, 1, 0);
        chk("ovf2_sticky", int'(overflow), 1);
        clrOvf = 1'b1;
        tick();
        clrOvf = 1'b0;
        chk("ovf2_clr", int'(overflow), 0);
        for (int i = 0; i < 16; i++) takeOne();
        chk("final_valid", int'(rxValid), 0);
        chk("final_queue", int'(expQ.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
